// File: rtl/i2c_slave_target.sv
// Oversampled I2C target: synchronises SCL/SDA, detects START/STOP, ACKs its own
// 7-bit address, delivers written bytes and serialises local data on reads.
`timescale 1ns/1ps
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b0101010,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       i2c_reset_n,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       addr_match,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [7:0]             shift, shift_n;
    logic                   sda_oe, sda_oe_n;
    logic                   rw, rw_n;
    logic [7:0]             rx_data_n;
    logic                   rx_valid_n, addr_match_n, busy_n;

    // Open drain: only ever pull low, otherwise leave the line to the pull-up.
    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    // Synchronisers idle at 1 so leaving reset on an idle bus produces no edge.
    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & ~sda_s & sda_prev;
    assign stop_det  = scl_s & scl_prev & sda_s & ~sda_prev;

    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            sda_oe     <= 1'b0;
            rw         <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            sda_oe     <= sda_oe_n;
            rw         <= rw_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            addr_match <= addr_match_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        sda_oe_n     = sda_oe;
        rw_n         = rw;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        addr_match_n = 1'b0;
        busy_n       = busy;
        tx_load      = 1'b0;

        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_det) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_n   = {shift[6:0], sda_s};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rw_n    = sda_s;
                        state_n = (shift[6:0] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                    end
                end
                // sda_oe doubles as the phase flag: first fall drives ACK, second ends it.
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_n     = 1'b1;
                        addr_match_n = 1'b1;
                        busy_n       = 1'b1;
                    end else if (!rw) begin
                        sda_oe_n = 1'b0;
                        state_n  = WRITE;
                    end else begin
                        tx_load  = 1'b1;
                        shift_n  = {tx_data[6:0], 1'b0};
                        sda_oe_n = ~tx_data[7];
                        state_n  = READ;
                    end
                end
                WRITE: if (scl_rise) begin
                    shift_n   = {shift[6:0], sda_s};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_n  = {shift[6:0], sda_s};
                        rx_valid_n = 1'b1;
                        state_n    = WR_ACK;
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = WRITE;
                    end
                end
                // Bit 7 is already on the wire; a fall with the count wrapped ends the byte.
                READ: begin
                    if (scl_rise) bit_cnt_n = bit_cnt + 3'd1;
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_n = 1'b0;
                            state_n  = RD_ACK;
                        end else begin
                            shift_n  = {shift[6:0], 1'b0};
                            sda_oe_n = ~shift[7];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_s) state_n = IGNORE;
                    if (scl_fall) begin
                        tx_load  = 1'b1;
                        shift_n  = {tx_data[6:0], 1'b0};
                        sda_oe_n = ~tx_data[7];
                        state_n  = READ;
                    end
                end
                IGNORE:  sda_oe_n = 1'b0;
                default: state_n  = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a behavioural bus master drives SCL/SDA while a
// negedge monitor logs DUT output events for the scoreboards to compare against.
`timescale 1ns/1ps
module tb_i2c_slave_target;
    localparam int Q = 80;  // quarter SCL period: 8 system clocks

    logic       clk = 1'b0;
    logic       i2c_reset_n;
    logic       scl;
    logic       m_sda_oe;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, tx_load, addr_match, busy;
    wire        sda;

    pullup (sda);
    assign sda = m_sda_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_target dut (
        .clk        (clk),
        .i2c_reset_n(i2c_reset_n),
        .i2c_scl    (scl),
        .i2c_sda    (sda),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_load    (tx_load),
        .addr_match (addr_match),
        .busy       (busy)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] rx_q[$];    // expected written bytes
    logic [7:0] rd_q[$];    // expected read bytes
    logic [7:0] rx_seen[$]; // rx_data observed on each rx_valid
    int         rx_idx = 0;

    int   rv_cnt = 0, tl_cnt = 0, am_cnt = 0, low_cnt = 0, wide_cnt = 0;
    logic prv_rv = 1'b0, prv_tl = 1'b0, prv_am = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            rv_cnt <= rv_cnt + 1;
            rx_seen.push_back(rx_data);
        end
        if (tx_load)    tl_cnt <= tl_cnt + 1;
        if (addr_match) am_cnt <= am_cnt + 1;
        if (sda === 1'b0 && !m_sda_oe) low_cnt <= low_cnt + 1;
        if ((rx_valid && prv_rv) || (tx_load && prv_tl) || (addr_match && prv_am))
            wide_cnt <= wide_cnt + 1;
        prv_rv <= rx_valid;
        prv_tl <= tx_load;
        prv_am <= addr_match;
    end

    // ---------------- bus master ----------------
    task automatic bus_start();
        m_sda_oe = 1'b0; #Q;
        scl = 1'b1;      #Q;
        m_sda_oe = 1'b1; #Q;
        scl = 1'b0;      #Q;
    endtask

    task automatic bus_stop();
        m_sda_oe = 1'b1; #Q;
        scl = 1'b1;      #Q;
        m_sda_oe = 1'b0; #(2*Q);
    endtask

    task automatic put_bit(input logic b);
        m_sda_oe = ~b; #Q;
        scl = 1'b1;    #(2*Q);
        scl = 1'b0;    #Q;
    endtask

    task automatic get_bit(output logic b);
        m_sda_oe = 1'b0; #Q;
        scl = 1'b1;      #Q;
        b = sda;         #Q;
        scl = 1'b0;      #Q;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i2c_reset_n = 1'b0;
        scl = 1'b1;
        m_sda_oe = 1'b0;
        tx_data = 8'h00;
        repeat (4) @(negedge clk);
        checks++;
        if ({rx_valid, tx_load, addr_match, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000", {rx_valid, tx_load, addr_match, busy});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data got=%h exp=00", rx_data);
        end
        checks++;
        if (sda !== 1'b1) begin
            errors++;
            $display("FAIL reset_sda got=%b exp=1", sda);
        end
        i2c_reset_n = 1'b1;
        #(2*Q);
    endtask

    task automatic test_write();
        int am0, rv0;
        logic ack;
        logic [7:0] exp;
        am0 = am_cnt;
        rv0 = rv_cnt;
        bus_start();
        put_byte(8'h54, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL write_addr_ack got=%b exp=0", ack); end
        rx_q.push_back(8'hAA);
        put_byte(8'hAA, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL write_data_ack got=%b exp=0", ack); end
        exp = rx_q.pop_front();
        checks++;
        if (rx_seen.size() != rx_idx + 1 || rx_seen[rx_idx] !== exp) begin
            errors++;
            $display("FAIL write_rx_data got_count=%0d got=%h exp=%h", rx_seen.size() - rx_idx, rx_seen[rx_idx], exp);
        end
        rx_idx = rx_seen.size();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_held got=%b exp=1", busy); end
        bus_stop();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
        checks++;
        if (am_cnt - am0 != 1) begin errors++; $display("FAIL write_addr_match got=%0d exp=1", am_cnt - am0); end
        checks++;
        if (rv_cnt - rv0 != 1) begin errors++; $display("FAIL write_rx_valid got=%0d exp=1", rv_cnt - rv0); end
    endtask

    task automatic test_addr_miss();
        int am0, rv0, low0;
        logic ack;
        am0 = am_cnt;
        rv0 = rv_cnt;
        low0 = low_cnt;
        bus_start();
        put_byte(8'h56, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL miss_addr_ack got=%b exp=1", ack); end
        put_byte(8'hAA, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL miss_data_ack got=%b exp=1", ack); end
        bus_stop();
        checks++;
        if (low_cnt != low0) begin errors++; $display("FAIL miss_sda_pulled got=%0d exp=0", low_cnt - low0); end
        checks++;
        if (am_cnt != am0 || rv_cnt != rv0) begin
            errors++;
            $display("FAIL miss_pulses got_am=%0d got_rv=%0d exp=0", am_cnt - am0, rv_cnt - rv0);
        end
        checks++;
        if (rx_data !== 8'hAA) begin errors++; $display("FAIL miss_rx_kept got=%h exp=aa", rx_data); end
        rx_idx = rx_seen.size();
    endtask

    task automatic test_read();
        int tl0, low0;
        logic ack;
        logic [7:0] d, exp;
        tl0 = tl_cnt;
        tx_data = 8'h3C;
        rd_q.push_back(8'h3C);
        rd_q.push_back(8'hC3);
        bus_start();
        put_byte(8'h55, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack got=%b exp=0", ack); end
        checks++;
        if (tl_cnt - tl0 != 1) begin errors++; $display("FAIL read_first_load got=%0d exp=1", tl_cnt - tl0); end
        tx_data = 8'hC3;
        get_byte(d);
        exp = rd_q.pop_front();
        checks++;
        if (d !== exp) begin errors++; $display("FAIL read_byte0 got=%h exp=%h", d, exp); end
        put_bit(1'b0);
        get_byte(d);
        exp = rd_q.pop_front();
        checks++;
        if (d !== exp) begin errors++; $display("FAIL read_byte1 got=%h exp=%h", d, exp); end
        low0 = low_cnt;
        put_bit(1'b1);
        #(2*Q);
        checks++;
        if (low_cnt != low0) begin errors++; $display("FAIL read_release_nack got=%0d exp=0", low_cnt - low0); end
        bus_stop();
        checks++;
        if (tl_cnt - tl0 != 2) begin errors++; $display("FAIL read_tx_loads got=%0d exp=2", tl_cnt - tl0); end
    endtask

    task automatic test_repeated_start();
        int am0, rv0;
        logic ack;
        logic [7:0] d, exp;
        am0 = am_cnt;
        rv0 = rv_cnt;
        rx_q.push_back(8'h11);
        tx_data = 8'h5A;
        rd_q.push_back(8'h5A);
        bus_start();
        put_byte(8'h54, ack);
        put_byte(8'h11, ack);
        exp = rx_q.pop_front();
        checks++;
        if (rx_seen.size() != rx_idx + 1 || rx_seen[rx_idx] !== exp) begin
            errors++;
            $display("FAIL rs_rx_data got_count=%0d got=%h exp=%h", rx_seen.size() - rx_idx, rx_seen[rx_idx], exp);
        end
        rx_idx = rx_seen.size();
        bus_start();
        put_byte(8'h55, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL rs_read_ack got=%b exp=0", ack); end
        get_byte(d);
        exp = rd_q.pop_front();
        checks++;
        if (d !== exp) begin errors++; $display("FAIL rs_read_byte got=%h exp=%h", d, exp); end
        put_bit(1'b1);
        bus_stop();
        checks++;
        if (am_cnt - am0 != 2 || rv_cnt - rv0 != 1) begin
            errors++;
            $display("FAIL rs_pulses got_am=%0d got_rv=%0d exp_am=2 exp_rv=1", am_cnt - am0, rv_cnt - rv0);
        end
        checks++;
        if (rx_data !== 8'h11) begin errors++; $display("FAIL rs_rx_kept got=%h exp=11", rx_data); end
    endtask

    task automatic test_reset_mid_ack();
        int am0;
        logic ack;
        logic [7:0] a, exp;
        a = 8'h54;
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(a[i]);
        m_sda_oe = 1'b0; #Q;
        scl = 1'b1;      #Q;
        checks++;
        if (sda !== 1'b0) begin errors++; $display("FAIL mid_ack_held got=%b exp=0", sda); end
        @(negedge clk);
        i2c_reset_n = 1'b0;
        #1;
        checks++;
        if (sda !== 1'b1) begin errors++; $display("FAIL mid_ack_release got=%b exp=1", sda); end
        checks++;
        if ({rx_valid, tx_load, addr_match, busy} !== 4'b0000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_ack_outputs got=%b/%h exp=0000/00", {rx_valid, tx_load, addr_match, busy}, rx_data);
        end
        #Q;
        scl = 1'b0; #Q;
        i2c_reset_n = 1'b1; #Q;
        bus_stop();
        am0 = am_cnt;
        rx_q.push_back(8'h77);
        bus_start();
        put_byte(8'h54, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL post_reset_ack got=%b exp=0", ack); end
        put_byte(8'h77, ack);
        exp = rx_q.pop_front();
        checks++;
        if (rx_seen.size() != rx_idx + 1 || rx_seen[rx_idx] !== exp) begin
            errors++;
            $display("FAIL post_reset_rx got_count=%0d got=%h exp=%h", rx_seen.size() - rx_idx, rx_seen[rx_idx], exp);
        end
        rx_idx = rx_seen.size();
        bus_stop();
        checks++;
        if (am_cnt - am0 != 1) begin errors++; $display("FAIL post_reset_match got=%0d exp=1", am_cnt - am0); end
    endtask

    task automatic test_aborted_byte();
        int am0, rv0;
        logic ack;
        am0 = am_cnt;
        rv0 = rv_cnt;
        bus_start();
        put_byte(8'h54, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL abort_addr_ack got=%b exp=0", ack); end
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b1);
        put_bit(1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_held got=%b exp=1", busy); end
        bus_stop();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_stop got=%b exp=0", busy); end
        checks++;
        if (rv_cnt != rv0 || rx_seen.size() != rx_idx) begin
            errors++;
            $display("FAIL abort_rx_valid got=%0d exp=0", rv_cnt - rv0);
        end
        checks++;
        if (am_cnt - am0 != 1) begin errors++; $display("FAIL abort_addr_match got=%0d exp=1", am_cnt - am0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_miss();
        test_read();
        test_repeated_start();
        test_reset_mid_ack();
        test_aborted_byte();
        checks++;
        if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
